register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of each register and data port.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, giving the address width; depth = 2**ADDR_WIDTH registers (32 by default).
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: RL  input  ADDR_WIDTH  left read-port address.
REQ-006 Port: RR  input  ADDR_WIDTH  right read-port address.
REQ-007 Port: RD  input  ADDR_WIDTH  destination (write) address.
REQ-008 Port: RD_data  input  DATA_WIDTH  write data.
REQ-009 Port: write  input  1  write enable, active-high.
REQ-010 Port: RL_data  output  DATA_WIDTH  data stored at RL.
REQ-011 Port: RR_data  output  DATA_WIDTH  data stored at RR.
REQ-012 Port order SHALL be clk, rst, RL, RR, RD, RD_data, write, RL_data, RR_data.

Function
REQ-013 Storage SHALL be 2**ADDR_WIDTH general registers, each DATA_WIDTH bits; all registers, including register 0, SHALL be writable (no hardwired zero).
REQ-014 On a rising clk edge with rst=0 and write=1, register[RD] SHALL take RD_data; no other register SHALL change.
REQ-015 On a rising clk edge with write=0, no register SHALL change.
REQ-016 Reads SHALL be asynchronous (combinational): RL_data = register[RL] and RR_data = register[RR] with zero-cycle latency.
REQ-017 Both read ports SHALL be independent; RL = RR SHALL return identical data on both outputs.
REQ-018 A register written on edge N SHALL be visible on the read outputs immediately after edge N.
REQ-019 X/unknown address values SHALL NOT corrupt stored data when write=0.

Reset
REQ-020 On a rising clk edge with rst=1, every register SHALL be cleared to 0; consequently RL_data and RR_data SHALL read 0 for every address after that edge.
REQ-021 rst=1 SHALL take priority over write=1 in the same cycle; the write SHALL be discarded.
REQ-022 Between power-up and the first reset edge, register contents are undefined, and verification SHALL NOT depend on them.

Configuration
REQ-023 When macro REGFILE_BYPASS_EN is defined, a read port whose address equals RD while write=1 and rst=0 SHALL output RD_data combinationally (write-through forwarding) in the same cycle, before the edge.
REQ-024 When REGFILE_BYPASS_EN is undefined, read ports SHALL output only the stored value; the new data SHALL appear only after the write edge.
REQ-025 The macro SHALL affect only the read-output path; the storage update and reset behaviour SHALL be identical in both builds.

Verification
REQ-026 Reset, then write=1 with RD=0, RD_data=12 for one edge, then RD=1, RD_data=16 for one edge, then write=0; with RR=0 and RL=1 -> RR_data=12 and RL_data=16.
REQ-027 After REQ-026, write=0 with RD=0, RD_data=99 for 3 edges -> RR=0 still reads 12.
REQ-028 Write 0xFFFFFFFF to R31 and set RL=RR=31 -> both outputs read 0xFFFFFFFF; then assert rst for one edge -> both outputs read 0.
REQ-029 rst=1 and write=1 with RD=5, RD_data=7 on the same edge -> R5 reads 0 afterwards.
REQ-030 R3 holds 1; drive write=1, RD=3, RD_data=2, RL=3 and sample before the edge -> RL_data=2 with REGFILE_BYPASS_EN defined, 1 without; after the edge -> 2 in both builds.

Source files
------------

// File: rtl/register_file.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file: two asynchronous read ports, one synchronous write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto a matching read port.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] RL,
    input  logic [ADDR_WIDTH-1:0] RR,
    input  logic [ADDR_WIDTH-1:0] RD,
    input  logic [DATA_WIDTH-1:0] RD_data,
    input  logic                  write,
    output logic [DATA_WIDTH-1:0] RL_data,
    output logic [DATA_WIDTH-1:0] RR_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    // NOTE: regs_d starts as a copy of regs_q so every path assigns it and no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        if (write) begin
            regs_d[RD] = RD_data;
        end
    end

    // NOTE: the array is cleared on reset because reads after reset must return 0, so it cannot map to reset-less RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every read in this edge sees pre-edge state.
            regs_q <= regs_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_active;

    always_comb begin
        fwd_active = write && !rst;
        RL_data    = regs_q[RL];
        RR_data    = regs_q[RR];
        if (fwd_active && (RL == RD)) begin
            RL_data = RD_data;
        end
        if (fwd_active && (RR == RD)) begin
            RR_data = RD_data;
        end
    end
`else
    always_comb begin
        RL_data = regs_q[RL];
        RR_data = regs_q[RR];
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table through a scoreboard queue plus
// hand-written pre-edge forwarding sequences (expectations follow REGFILE_BYPASS_EN).
module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic [AW-1:0] RL, RR, RD;
    logic [DW-1:0] RD_data;
    logic          write;
    logic [DW-1:0] RL_data, RR_data;

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .RL     (RL),
        .RR     (RR),
        .RD     (RD),
        .RD_data(RD_data),
        .write  (write),
        .RL_data(RL_data),
        .RR_data(RR_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          rst;
        logic          write;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic [AW-1:0] rl;
        logic [AW-1:0] rr;
        logic [DW-1:0] exp_l;
        logic [DW-1:0] exp_r;
    } vec_t;

    typedef struct {
        string         name;
        logic [DW-1:0] exp_l;
        logic [DW-1:0] exp_r;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[14];

    int n_checks = 0;
    int n_pass   = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [AW-1:0] rd,
                         input logic [DW-1:0] d, input logic [AW-1:0] rl, input logic [AW-1:0] rr);
        rst     = r;
        write   = w;
        RD      = rd;
        RD_data = d;
        RL      = rl;
        RR      = rr;
    endtask

    // Drive on the falling edge, queue the expectation, compare 1 time unit after the rising edge.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        drive(v.rst, v.write, v.rd, v.data, v.rl, v.rr);
        exp_q.push_back('{v.name, v.exp_l, v.exp_r});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({v.name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({e.name, "_RL"}, RL_data, e.exp_l);
            check({e.name, "_RR"}, RR_data, e.exp_r);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          name          rst   wr    rd     data           rl     rr     exp_l          exp_r
        vecs[0]  = '{"reset",      1'b1, 1'b0, 5'd0,  32'd0,         5'd0,  5'd31, 32'd0,         32'd0};
        vecs[1]  = '{"wr_r0",      1'b0, 1'b1, 5'd0,  32'd12,        5'd0,  5'd1,  32'd12,        32'd0};
        vecs[2]  = '{"wr_r1",      1'b0, 1'b1, 5'd1,  32'd16,        5'd1,  5'd0,  32'd16,        32'd12};
        vecs[3]  = '{"nowr_1",     1'b0, 1'b0, 5'd0,  32'd99,        5'd1,  5'd0,  32'd16,        32'd12};
        vecs[4]  = '{"nowr_2",     1'b0, 1'b0, 5'd0,  32'd99,        5'd1,  5'd0,  32'd16,        32'd12};
        vecs[5]  = '{"nowr_3",     1'b0, 1'b0, 5'd0,  32'd99,        5'd1,  5'd0,  32'd16,        32'd12};
        vecs[6]  = '{"wr_r31",     1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[7]  = '{"rst_r31",    1'b1, 1'b0, 5'd0,  32'd0,         5'd31, 5'd31, 32'd0,         32'd0};
        vecs[8]  = '{"wr_r5",      1'b0, 1'b1, 5'd5,  32'hA5A5_A5A5, 5'd5,  5'd0,  32'hA5A5_A5A5, 32'd0};
        vecs[9]  = '{"rst_pri",    1'b1, 1'b1, 5'd5,  32'd7,         5'd5,  5'd5,  32'd0,         32'd0};
        vecs[10] = '{"wr_r2",      1'b0, 1'b1, 5'd2,  32'h0000_1234, 5'd2,  5'd5,  32'h0000_1234, 32'd0};
        vecs[11] = '{"wr_r7",      1'b0, 1'b1, 5'd7,  32'hDEAD_BEEF, 5'd2,  5'd7,  32'h0000_1234, 32'hDEAD_BEEF};
        vecs[12] = '{"ovr_r2",     1'b0, 1'b1, 5'd2,  32'h5555_5555, 5'd2,  5'd7,  32'h5555_5555, 32'hDEAD_BEEF};
        vecs[13] = '{"x_addr",     1'b0, 1'b0, 5'bx,  32'hFFFF_0000, 5'd7,  5'd2,  32'hDEAD_BEEF, 32'h5555_5555};

        drive(1'b0, 1'b0, '0, '0, '0, '0);
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i]);
        end

        // R3 <= 1, then present a write of 2 to R3 while reading it on RL.
        apply('{"wr_r3", 1'b0, 1'b1, 5'd3, 32'd1, 5'd3, 5'd4, 32'd1, 32'd0});
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd3, 32'd2, 5'd3, 5'd4);
        #1;
        check("fwd_rl_pre", RL_data, BYPASS ? 32'd2 : 32'd1);
        check("fwd_rl_other", RR_data, 32'd0);
        @(posedge clk);
        #1;
        check("fwd_rl_post", RL_data, 32'd2);

        // Same on the right port.
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd3, 32'd9, 5'd4, 5'd3);
        #1;
        check("fwd_rr_pre", RR_data, BYPASS ? 32'd9 : 32'd2);
        check("fwd_rr_other", RL_data, 32'd0);
        @(posedge clk);
        #1;
        check("fwd_rr_post", RR_data, 32'd9);

        // Reset with a pending write: never forwarded, and R3 clears.
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd3, 32'd5, 5'd3, 5'd3);
        #1;
        check("rst_nofwd_pre", RL_data, 32'd9);
        @(posedge clk);
        #1;
        check("rst_nofwd_post_RL", RL_data, 32'd0);
        check("rst_nofwd_post_RR", RR_data, 32'd0);

        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0, '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
